// File: rtl/bsa_pkg.sv
// Shared types and helpers for the bit-serial adder controller.
// Holds the FSM state encoding and the bit-counter width function.
package bsa_pkg;

    typedef enum logic [1:0] {
        BSA_IDLE,
        BSA_RUN,
        BSA_DONE
    } bsa_state_t;

    localparam int BSA_WIDTH_MIN = 2;
    localparam int BSA_WIDTH_MAX = 64;

    // Width of the bit counter; it counts 0..width-1.
    function automatic int bsa_cnt_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/bit_serial_add_ctrl_if.sv
// Operand/result handshake bundle for bit_serial_add_ctrl.
// master: producer+consumer side; slave: the adder controller.
// Optional BSA_SUB_EN adds the 1-bit sub request.
interface bit_serial_add_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef BSA_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;

`ifdef BSA_SUB_EN
    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout
    );
    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout
    );
`else
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout
    );
    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout
    );
`endif

endinterface

// File: rtl/bit_serial_add_ctrl_fa_cell.sv
// Combinational 1-bit full adder used by the serial sequencer.
// Ports: a, b, c in; s = a^b^c, co = majority(a,b,c) out.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ c;
    assign co = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/bit_serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder cell stepped LSB first
// over WIDTH bits, with valid/ready on operand and result sides.
// Ports: clk, rst_n (synchronous, active-low), bus (slave modport of
// bit_serial_add_ctrl_if: in_valid/in_ready/a/b/cin, out_valid/
// out_ready/sum/cout). Optional macro BSA_SUB_EN adds bus.sub for
// a - b via a + ~b + 1.
module bit_serial_add_ctrl
    import bsa_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    bit_serial_add_ctrl_if.slave  bus
);

    localparam int CW = bsa_cnt_w(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    if (WIDTH < BSA_WIDTH_MIN || WIDTH > BSA_WIDTH_MAX) begin : g_bad_width
        $error("bit_serial_add_ctrl: WIDTH out of range 2..64");
    end

    bsa_state_t       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic             fa_s;
    logic             fa_co;
    logic [WIDTH-1:0] b_load;
    logic             carry_load;

    fa_cell u_fa (
        .a  (a_sh_q[0]),
        .b  (b_sh_q[0]),
        .c  (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

`ifdef BSA_SUB_EN
    // Subtract as a + ~b + 1; the forced carry-in replaces cin.
    assign b_load     = bus.sub ? ~bus.b : bus.b;
    assign carry_load = bus.sub ? 1'b1 : bus.cin;
`else
    assign b_load     = bus.b;
    assign carry_load = bus.cin;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        carry_d     = carry_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            BSA_IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    a_sh_d     = bus.a;
                    b_sh_d     = b_load;
                    carry_d    = carry_load;
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = BSA_RUN;
                end
            end
            BSA_RUN: begin
                // Result bits enter at the MSB so after WIDTH steps
                // the first bit has reached bit 0.
                sum_d   = {fa_s, sum_q[WIDTH-1:1]};
                carry_d = fa_co;
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    cnt_d       = '0;
                    cout_d      = fa_co;
                    out_valid_d = 1'b1;
                    state_d     = BSA_DONE;
                end
            end
            BSA_DONE: begin
                // in_ready rises only after retirement, so a new
                // operand pair waits at least one more cycle.
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = BSA_IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = BSA_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= BSA_IDLE;
            cnt_q       <= '0;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            carry_q     <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            carry_q     <= carry_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;

endmodule
